prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the pipelined RISC-V core. It receives a byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words into the instruction memory that the fetch stage reads. It holds the core in reset until a complete, checksum-verified image has been written, then releases it.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2^ADDR_W

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- rx_valid  in  1  byte-stream source has a byte
- rx_data  in  8  byte value
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- core_srst  out  1  reset to the core; high while loading or after an error
- load_done  out  1  image loaded and verified; sticky
- load_err  out  1  header or checksum error; sticky

## Operation
- Stream format: COUNT_LO, COUNT_HI (16-bit word count, little-endian), then COUNT×4 data bytes with each word little-endian, then one CSUM byte.
- The CSUM byte is the XOR of all preceding bytes: both header bytes and all data bytes.
- A byte is accepted on a rising edge where rx_valid & rx_ready. No other edge changes the byte-path state.
- FSM states: HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR.
- **HDR_LO:** on accept, capture the low count byte and go to HDR_HI.
- **HDR_HI:** on accept, form the count.
  - Count == 0 or count > MAX_WORDS: go to ERROR.
  - Otherwise: go to DATA.
- **DATA:** a 2-bit byte counter shifts each byte into the word assembly register at its little-endian position.
  - On the 4th byte, register imem_we=1, imem_wdata=assembled word, and imem_addr=word_idx; then increment word_idx.
  - After the word at index count−1, go to CSUM.
- **CSUM:** on accept, compare the byte to the running XOR.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- **DONE:** terminal until srst. Outputs: load_done=1, core_srst=0.
- **ERROR:** terminal until srst. Outputs: load_err=1, core_srst=1.
- rx_ready = 1 in HDR_LO, HDR_HI, DATA and CSUM; 0 in DONE and ERROR. It is a combinational decode of the registered state and does not depend on rx_valid.
- Running XOR is updated on every accepted byte in HDR_LO, HDR_HI and DATA.
- Bytes offered while rx_ready=0 are ignored and have no side effects.

## Timing
- Reset values:
  - state = HDR_LO, core_srst = 1, rx_ready = 1
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - load_done = 0, load_err = 0
  - word_idx, byte counter and XOR all 0
- srst asserted mid-load: on the next edge, return to the reset values. imem_we must not be asserted on the cycle after the srst edge. Words already written remain in memory and are not cleared.
- Write latency: imem_we is high in exactly the cycle after the edge that accepted the 4th byte of a word, and low otherwise. The minimum spacing between strobes is 4 cycles.
- DONE/ERROR entry: state, load_done/load_err and core_srst all update on the same edge that accepted the CSUM byte. For a bad header, the update happens on the edge that accepted COUNT_HI.
- Accepting one byte per cycle back-to-back must be supported. Gaps in rx_valid stall the FSM with no state change.
- word_idx is ADDR_W+1 bits wide. The last word written is at address count−1 and never wraps.

## Test plan
- **Minimal good image:** stream 01 00 93 00 50 00 C2, back-to-back.
  - One imem_we pulse with addr 0 and wdata 0x00500093.
  - load_done=1 and core_srst=0 on the edge after C2 is accepted.
  - rx_ready=0 afterwards.
- **Bad checksum:** same stream with CSUM=C3.
  - The word is still written.
  - load_err=1 and core_srst stays 1.
  - Further bytes are ignored.
- **Bad header:** stream 00 00 → ERROR after the 2nd byte, no writes. Repeat with count 0x0101 against MAX_WORDS=256 → ERROR after the 2nd byte, no writes.
- **Multi-word with gaps:** 3-word image with rx_valid toggled randomly.
  - Exactly 3 strobes at addresses 0, 1, 2 with the correct words.
  - load_done set only after the correct CSUM byte.
- **Reset mid-load:** assert srst after the 6th byte of a 2-word image.
  - All outputs return to reset values, with core_srst=1.
  - A full valid image re-streamed afterwards loads correctly from address 0.
- **Full size:** MAX_WORDS-word image streamed back-to-back.
  - The last strobe is at addr MAX_WORDS−1.
  - load_done=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream and instruction-memory write bundle for prog_loader
//
// Purpose: groups the loader's byte-stream handshake and its instruction-memory
// write port into one interface.
// Signals:
//   rx_valid   source has a byte
//   rx_data    byte value
//   rx_ready   loader accepts a byte this cycle
//   imem_we    instruction-memory write strobe, one cycle per word
//   imem_addr  word address of the write
//   imem_wdata instruction word
// Modports:
//   master  byte source / memory side (drives rx_valid, rx_data)
//   slave   the loader (drives rx_ready and the write port)
interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time program loader packing a byte stream into instruction memory
//
// Purpose: receives COUNT_LO, COUNT_HI, COUNT*4 little-endian data bytes and a
// XOR checksum byte, writes each assembled 32-bit word to instruction memory,
// and holds the core in reset until the whole image is written and verified.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset
//   bus        prog_loader_if.slave (rx_valid/rx_data/rx_ready, imem_we/imem_addr/imem_wdata)
//   core_srst  reset to the core; high unless the image loaded and verified
//   load_done  image loaded and verified (sticky until srst)
//   load_err   header or checksum error (sticky until srst)
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          srst,
  prog_loader_if.slave  bus,
  output logic          core_srst,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [ADDR_W:0]   last_idx_q, last_idx_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;

  logic        rx_ready;
  logic        accept;
  logic [15:0] count16;

  // Ready is a pure decode of the registered state so the source never sees
  // a combinational path back from rx_valid.
  assign rx_ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign accept   = bus.rx_valid && rx_ready;
  assign count16  = {bus.rx_data, cnt_lo_q};

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    last_idx_d   = last_idx_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      case (state_q)
        HDR_LO: begin
          cnt_lo_d = bus.rx_data;
          xor_d    = xor_q ^ bus.rx_data;
          state_d  = HDR_HI;
        end
        HDR_HI: begin
          xor_d = xor_q ^ bus.rx_data;
          if ((count16 == 16'd0) || ({1'b0, count16} > 17'(MAX_WORDS))) begin
            state_d = ERROR;
          end else begin
            // Store count-1 so the last-word test is a plain equality on word_idx.
            last_idx_d = count16[ADDR_W:0] - {{ADDR_W{1'b0}}, 1'b1};
            state_d    = DATA;
          end
        end
        DATA: begin
          xor_d      = xor_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              // The 4th byte goes straight into the write data, not word_q.
              imem_we_d    = 1'b1;
              imem_wdata_d = {bus.rx_data, word_q};
              imem_addr_d  = word_idx_q[ADDR_W-1:0];
              word_idx_d   = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
              if (word_idx_q == last_idx_q) begin
                state_d = CSUM;
              end
            end
          endcase
        end
        CSUM: begin
          state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= HDR_LO;
      cnt_lo_q     <= '0;
      last_idx_q   <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      xor_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      last_idx_q   <= last_idx_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      xor_q        <= xor_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;

  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERROR);
  assign core_srst = (state_q != DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic clk;
  logic srst;
  logic core_srst, load_done, load_err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .srst      (srst),
    .bus       (bus.slave),
    .core_srst (core_srst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       img_words[$];
  logic [7:0]        stream_q[$];

  // Write monitor: every strobe seen mid-cycle is one memory write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    srst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},  32'(bus.rx_ready),   32'd1);
    check({tag, "_core_srst"}, 32'(core_srst),      32'd1);
    check({tag, "_done"},      32'(load_done),      32'd0);
    check({tag, "_err"},       32'(load_err),       32'd0);
    check({tag, "_we"},        32'(bus.imem_we),    32'd0);
    check({tag, "_addr"},      32'(bus.imem_addr),  32'd0);
    check({tag, "_wdata"},     bus.imem_wdata,      32'd0);
  endtask

  // Offers one byte for exactly one cycle; optional random idle gap first
  // with junk data on the bus and rx_valid low.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic rand_words(input int n);
    img_words.delete();
    repeat (n) img_words.push_back($urandom);
  endtask

  // Reference stream: header, little-endian words, XOR of everything before.
  task automatic build_stream(input int count, input bit bad_csum);
    logic [7:0] x;
    logic [31:0] w;
    stream_q.delete();
    stream_q.push_back(count[7:0]);
    stream_q.push_back(count[15:8]);
    foreach (img_words[i]) begin
      w = img_words[i];
      for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
    end
    x = 8'h00;
    foreach (stream_q[i]) x ^= stream_q[i];
    if (bad_csum) x ^= 8'h01;
    stream_q.push_back(x);
  endtask

  task automatic send_range(input int from, input int to_excl, input int gap_pct);
    for (int i = from; i < to_excl; i++) send_byte(stream_q[i], gap_pct);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(img_words.size()));
    n = (wr_data_q.size() < img_words.size()) ? wr_data_q.size() : img_words.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], img_words[i]);
    end
  endtask

  initial begin
    logic [7:0] ex1 [7];
    srst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_values("reset");

    // Minimal good image, back-to-back.
    ex1 = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    for (int i = 0; i < 5; i++) send_byte(ex1[i], 0);
    check("min_we_before", 32'(bus.imem_we), 32'd0);
    send_byte(ex1[5], 0);
    check("min_we_pulse",  32'(bus.imem_we), 32'd1);
    check("min_addr",      32'(bus.imem_addr), 32'd0);
    check("min_wdata",     bus.imem_wdata, 32'h00500093);
    check("min_done_pre",  32'(load_done), 32'd0);
    send_byte(ex1[6], 0);
    check("min_we_after",  32'(bus.imem_we), 32'd0);
    check("min_done",      32'(load_done), 32'd1);
    check("min_core_srst", 32'(core_srst), 32'd0);
    check("min_err",       32'(load_err), 32'd0);
    check("min_ready",     32'(bus.rx_ready), 32'd0);
    img_words.delete(); img_words.push_back(32'h00500093);
    check_writes("min");

    // Bad checksum: word still written, error sticky, later bytes ignored.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(ex1[i], 0);
    send_byte(8'hC3, 0);
    check("bcs_err",       32'(load_err), 32'd1);
    check("bcs_done",      32'(load_done), 32'd0);
    check("bcs_core_srst", 32'(core_srst), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(ex1[i], 0);
    repeat (2) @(posedge clk); #1;
    check("bcs_err_hold",  32'(load_err), 32'd1);
    check("bcs_ready",     32'(bus.rx_ready), 32'd0);
    check_writes("bcs");

    // Bad headers: zero count and count above MAX_WORDS.
    do_reset();
    send_byte(8'h00, 0);
    check("hz_err_early", 32'(load_err), 32'd0);
    send_byte(8'h00, 0);
    check("hz_err", 32'(load_err), 32'd1);
    check("hz_core_srst", 32'(core_srst), 32'd1);
    repeat (4) send_byte(8'h11, 0);
    check("hz_nwr", 32'(wr_data_q.size()), 32'd0);

    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("hbig_err", 32'(load_err), 32'd1);
    check("hbig_ready", 32'(bus.rx_ready), 32'd0);
    repeat (4) send_byte(8'h22, 0);
    check("hbig_nwr", 32'(wr_data_q.size()), 32'd0);

    // Multi-word with random gaps.
    do_reset();
    rand_words(3);
    build_stream(3, 1'b0);
    send_range(0, stream_q.size() - 1, 50);
    check("gap_done_pre", 32'(load_done), 32'd0);
    send_range(stream_q.size() - 1, stream_q.size(), 50);
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_core_srst", 32'(core_srst), 32'd0);
    check_writes("gap");

    // Reset after the 6th byte of a 2-word image, then a full reload.
    do_reset();
    rand_words(2);
    build_stream(2, 1'b0);
    send_range(0, 6, 0);
    check("rml_we_pre", 32'(bus.imem_we), 32'd1);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    check_reset_values("rml");
    check("rml_nwr_before", 32'(wr_data_q.size()), 32'd1);
    wr_addr_q.delete(); wr_data_q.delete();
    rand_words(2);
    build_stream(2, 1'b0);
    send_range(0, stream_q.size(), 30);
    check("rml_done", 32'(load_done), 32'd1);
    check_writes("rml");

    // Full-size image, back-to-back.
    do_reset();
    rand_words(MAX_WORDS);
    build_stream(MAX_WORDS, 1'b0);
    send_range(0, stream_q.size(), 0);
    check("full_done", 32'(load_done), 32'd1);
    check("full_err", 32'(load_err), 32'd0);
    check("full_last_addr",
          (wr_addr_q.size() > 0) ? 32'(wr_addr_q[wr_addr_q.size()-1]) : 32'hFFFF_FFFF,
          32'(MAX_WORDS - 1));
    check_writes("full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
